// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//
// Fetch-to-decode pipeline stage with a DEPTH-entry instruction queue sitting
// behind a registered decode-side output. Fetch keeps filling the queue while
// decode is stalled; a redirect flush discards everything in flight.
//
// When the queue is empty and decode is not stalled, a fetched instruction
// bypasses the queue and lands in the output register on the next edge, so
// the stage keeps the 1-cycle latency of a plain IF/ID register.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   if_valid      fetch presents an instruction this cycle
//   if_ready      queue can accept (registered count < DEPTH)
//   if_pc_plus_4  fetch PC+4 (word address)
//   if_ins        fetched instruction
//   flush         redirect: empty the queue, bubble the output
//   hold          decode stall: freeze the output, queue may still fill
//   id_valid      id_ins is a real instruction (0 = NOP bubble)
//   id_ins        registered decode instruction
//   id_pc_plus_4  registered decode PC+4
//   count         entries held in the queue, output register excluded
//
// Per-edge priority: flush > hold > advance.
// ---------------------------------------------------------------------------
module if_id_queue #(
    parameter int               PC_W  = 30,
    parameter int               INS_W = 32,
    parameter int               DEPTH = 4,
    parameter logic [INS_W-1:0] NOP   = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       if_valid,
    output logic                       if_ready,
    input  logic [PC_W-1:0]            if_pc_plus_4,
    input  logic [INS_W-1:0]           if_ins,
    input  logic                       flush,
    input  logic                       hold,
    output logic                       id_valid,
    output logic [INS_W-1:0]           id_ins,
    output logic [PC_W-1:0]            id_pc_plus_4,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Storage carries no reset; only pointers and count define what is live.
    logic [INS_W-1:0] ins_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem  [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic push;
    logic q_empty;
    logic bypass;
    logic wr_en;
    logic pop;

    // Ready comes from the registered count only, so a slot freed by a pop
    // is not offered to fetch until the following cycle.
    assign if_ready = (count < CNT_W'(DEPTH));
    assign push     = if_valid && if_ready;
    assign q_empty  = (count == '0);

    // Empty queue, decode advancing: the input goes straight to the output.
    assign bypass   = !flush && !hold && q_empty && push;
    // Any accepted push that is neither dropped by flush nor bypassed lands in
    // the queue; while advancing with entries ahead, it queues behind them.
    assign wr_en    = push && !flush && !bypass;
    assign pop      = !flush && !hold && !q_empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ins_mem[wr_ptr] <= if_ins;
            pc_mem[wr_ptr]  <= if_pc_plus_4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !wr_en) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid     <= 1'b0;
            id_ins       <= NOP;
            id_pc_plus_4 <= '0;
        end else if (flush) begin
            // Bubble carries the redirect PC+4 so downstream sees where fetch went.
            id_valid     <= 1'b0;
            id_ins       <= NOP;
            id_pc_plus_4 <= if_pc_plus_4;
        end else if (!hold) begin
            if (pop) begin
                id_valid     <= 1'b1;
                id_ins       <= ins_mem[rd_ptr];
                id_pc_plus_4 <= pc_mem[rd_ptr];
            end else if (bypass) begin
                id_valid     <= 1'b1;
                id_ins       <= if_ins;
                id_pc_plus_4 <= if_pc_plus_4;
            end else begin
                id_valid     <= 1'b0;
                id_ins       <= NOP;
            end
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam int PC_W  = 30;
    localparam int INS_W = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [INS_W-1:0] NOP = '0;

    logic              clk;
    logic              rst_n;
    logic              if_valid;
    logic              if_ready;
    logic [PC_W-1:0]   if_pc_plus_4;
    logic [INS_W-1:0]  if_ins;
    logic              flush;
    logic              hold;
    logic              id_valid;
    logic [INS_W-1:0]  id_ins;
    logic [PC_W-1:0]   id_pc_plus_4;
    logic [CNT_W-1:0]  count;

    if_id_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc_plus_4(if_pc_plus_4), .if_ins(if_ins),
        .flush(flush), .hold(hold),
        .id_valid(id_valid), .id_ins(id_ins), .id_pc_plus_4(id_pc_plus_4),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a FIFO of fetched instructions plus the decode-side register.
    typedef struct {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] ins;
    } ent_t;

    ent_t             q[$];
    logic             m_valid;
    logic [INS_W-1:0] m_ins;
    logic [PC_W-1:0]  m_pc;

    int n_cmp  = 0;
    int n_fail = 0;
    bit last_push;

    logic [PC_W-1:0]  cur_pc;
    logic [INS_W-1:0] cur_ins;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_ins   = NOP;
        m_pc    = '0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".id_valid"}, 64'(id_valid), 64'(m_valid));
        chk({tag, ".id_ins"},   64'(id_ins),   64'(m_ins));
        chk({tag, ".id_pc"},    64'(id_pc_plus_4), 64'(m_pc));
        chk({tag, ".count"},    64'(count),    64'(q.size()));
    endtask

    // One clock: drive inputs, predict, take the edge, compare 1 time unit later.
    task automatic step(input string tag, input logic v, input logic [PC_W-1:0] pc,
                        input logic [INS_W-1:0] ins, input logic fl, input logic hd);
        bit   rdy;
        bit   psh;
        ent_t e;
        if_valid     = v;
        if_pc_plus_4 = pc;
        if_ins       = ins;
        flush        = fl;
        hold         = hd;
        rdy = (q.size() < DEPTH);
        chk({tag, ".if_ready"}, 64'(if_ready), 64'(rdy));
        psh = v && rdy;
        if (fl) begin
            q.delete();
            m_valid = 1'b0;
            m_ins   = NOP;
            m_pc    = pc;
        end else if (hd) begin
            if (psh) q.push_back('{pc, ins});
        end else if (q.size() > 0) begin
            e = q.pop_front();
            m_valid = 1'b1;
            m_ins   = e.ins;
            m_pc    = e.pc;
            if (psh) q.push_back('{pc, ins});
        end else if (psh) begin
            m_valid = 1'b1;
            m_ins   = ins;
            m_pc    = pc;
        end else begin
            m_valid = 1'b0;
            m_ins   = NOP;
        end
        last_push = psh;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic next_item();
        cur_pc  = cur_pc + 30'd1;
        cur_ins = $urandom;
    endtask

    // Fetch-like source: keeps presenting the same item until it is accepted.
    task automatic feed(input string tag, input logic fl, input logic hd);
        step(tag, 1'b1, cur_pc, cur_ins, fl, hd);
        if (last_push || fl) next_item();
    endtask

    task automatic idle(input string tag, input logic hd);
        step(tag, 1'b0, cur_pc, cur_ins, 1'b0, hd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        if_valid     = 1'b0;
        if_pc_plus_4 = '0;
        if_ins       = '0;
        flush        = 1'b0;
        hold         = 1'b0;
        cur_pc       = 30'h400;
        cur_ins      = 32'h1234_5678;
        model_reset();

        #2;
        check_outputs("reset");
        chk("reset.if_ready", 64'(if_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Stream A, B, C with no stall: each appears one edge after its push.
        step("strA", 1'b1, 30'h10, 32'h8C01_0004, 1'b0, 1'b0);
        chk("strA.direct", 64'(id_ins), 64'h8C01_0004);
        step("strB", 1'b1, 30'h11, 32'h2002_0005, 1'b0, 1'b0);
        chk("strB.direct", 64'(id_ins), 64'h2002_0005);
        step("strC", 1'b1, 30'h12, 32'h0043_1820, 1'b0, 1'b0);
        chk("strC.count0", 64'(count), 64'd0);
        idle("strIdle", 1'b0);
        chk("strIdle.bubble", 64'(id_valid), 64'd0);

        // Decode stall for 6 cycles with fetch pushing; 5th item must wait.
        for (int i = 0; i < 6; i++) feed("hold", 1'b0, 1'b1);
        chk("hold.full", 64'(count), 64'(DEPTH));
        chk("hold.ready0", 64'(if_ready), 64'd0);
        for (int i = 0; i < 7; i++) feed("release", 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) idle("drain", 1'b0);

        // Fill to 3 then flush with a push pending: push is dropped.
        for (int i = 0; i < 3; i++) feed("fill3", 1'b0, 1'b1);
        step("flush", 1'b1, 30'h100, 32'hDEAD_BEEF, 1'b1, 1'b0);
        chk("flush.pc", 64'(id_pc_plus_4), 64'h100);
        chk("flush.ins", 64'(id_ins), 64'h0);
        idle("postflush", 1'b0);

        // Flush and hold together with count=2: flush wins.
        for (int i = 0; i < 2; i++) feed("fill2", 1'b0, 1'b1);
        step("flushhold", 1'b1, 30'h200, 32'hCAFE_0001, 1'b1, 1'b1);
        chk("flushhold.count", 64'(count), 64'd0);
        idle("postfh", 1'b0);

        // Three full fill/drain cycles so the pointers wrap.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) feed("wrapfill", 1'b0, 1'b1);
            for (int i = 0; i < DEPTH + 1; i++) idle("wrapdrain", 1'b0);
        end

        // Async reset between edges with count=3.
        for (int i = 0; i < 3; i++) feed("prerst", 1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("asyncrst");
        chk("asyncrst.if_ready", 64'(if_ready), 64'd1);
        #2;
        rst_n = 1'b1;
        feed("rstbypass", 1'b0, 1'b0);
        chk("rstbypass.valid", 64'(id_valid), 64'd1);

        // Randomized traffic against the reference FIFO.
        for (int i = 0; i < 400; i++) begin
            logic v, fl, hd;
            v  = ($urandom_range(0, 3) != 0);
            hd = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 15) == 0);
            if (v) feed("rand", fl, hd);
            else   step("rand", 1'b0, cur_pc, cur_ins, fl, hd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- Adds a DEPTH-entry fetch queue between IF and ID, so fetch continues while decode is stalled.
- Carries an explicit valid bit and redirect flush. Bubbles are NOP with valid=0.
- Registered decode-side output; same 1-cycle IF-to-ID latency as the single-entry register when the queue is empty.

Parameters:
- PC_W, 30, width of pc_plus_4 (word address).
- INS_W, 32, instruction width.
- DEPTH, 4, queue entries behind the output register; power of 2, ≥2.
- NOP, {INS_W{1'b0}}, instruction value driven on bubbles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch presents an instruction this cycle.
- if_ready  out  1  queue can accept; = (count < DEPTH), from registered count only.
- if_pc_plus_4  in  PC_W  fetch PC+4.
- if_ins  in  INS_W  fetched instruction.
- flush  in  1  redirect (taken branch/jump/jal/jalr/eret/syscall), decoded upstream.
- hold  in  1  decode stall (load-use hazard or branch bubble).
- id_valid  out  1  id_ins is a real instruction.
- id_ins  out  INS_W  registered decode instruction.
- id_pc_plus_4  out  PC_W  registered decode PC+4.
- count  out  $clog2(DEPTH+1)  entries in queue, excluding the output register.

Behaviour:
- Reset (async, rst_n=0): id_valid=0, id_ins=NOP, id_pc_plus_4=0, count=0, rd_ptr=wr_ptr=0. Takes effect immediately, mid-operation included; all queue contents are discarded.
- push = if_valid && if_ready. Input is ignored when if_ready=0.
- Per rising edge, priority flush > hold > advance:
  - flush=1:
    - queue emptied (count=0, rd_ptr=wr_ptr).
    - id_valid=0, id_ins=NOP, id_pc_plus_4=if_pc_plus_4.
    - The same-cycle push is dropped.
    - hold is ignored.
  - hold=1, flush=0:
    - id_* held unchanged.
    - push writes the queue at wr_ptr; count+1.
  - advance (flush=0, hold=0):
    - count>0: output loads queue head (valid=1), rd_ptr+1. A simultaneous push writes at wr_ptr, so count is unchanged; otherwise count-1.
    - count=0 with push: bypass. Input loads the output directly (valid=1) and is not written to the queue.
    - count=0 without push: id_valid=0, id_ins=NOP, id_pc_plus_4 unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Full (count=DEPTH): if_ready=0. No push in the cycle a pop occurs, even though a slot frees; refill starts the following cycle.
- Ordering is strict FIFO; no instruction is duplicated or lost except by flush.
- Latency: 1 cycle with an empty queue and no hold; otherwise 1 + entries ahead.
- The queue holds only valid entries; id_valid=0 is used only for NOP bubbles.
- Storage is a register array without reset (pointers/count are reset). Implementation: 120–250 lines.

Test Plan:
- Stream with hold=0: push ins A=0x8C010004, B, C on consecutive cycles.
  - A appears at id one edge after push, then B, C.
  - count stays 0; if_ready=1 throughout.
- hold=1 for 6 cycles while pushing 5 ins (DEPTH=4).
  - count 1,2,3,4; if_ready=0 at count=4; 5th ins held by fetch.
  - id_* frozen.
  - Release hold: order preserved; 5th ins accepted the cycle after first pop.
- Fill to count=3, then assert flush with if_valid=1, if_pc_plus_4=0x100.
  - Next edge: count=0, id_valid=0, id_ins=0, id_pc_plus_4=0x100.
  - The flush-cycle push is absent.
- flush and hold asserted together with count=2: flush wins. Queue empty, bubble output.
- Wrap-around: 3 full fill/drain cycles with DEPTH=4; pointers pass index 3→0 with no corruption. Compare against a scoreboard FIFO model.
- Drop rst_n asynchronously mid-stream (between edges, count=3).
  - Outputs go to reset values immediately; count=0; if_ready=1.
  - First push after release bypasses to id on the next edge.
